// File: rtl/ws2811_pkg.sv
// Shared types and width helpers for the WS2811 pixel streaming path.
package ws2811_pkg;

   typedef logic [23:0] rgb24_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_ROM,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_WAIT_DONE,
      ST_DONE
   } seq_state_t;

   localparam int DEFAULT_UNITS_NUMBER          = 100;
   localparam int DEFAULT_PATTERN_COLORS_NUMBER = 128;
   localparam int DEFAULT_PATTERNS_NUMBER       = 4;
   localparam int DEFAULT_CW = $clog2(DEFAULT_PATTERN_COLORS_NUMBER);
   localparam int DEFAULT_PW = $clog2(DEFAULT_PATTERNS_NUMBER);

   // Index width for a count of n items; never narrower than one bit so a
   // single-entry table still gets a legal vector.
   function automatic int index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pattern_index_control.sv
// Pending pattern selector: wrap-around up/down counter driven by IR
// next/prev pulses. Simultaneous next and prev cancel out.
module pattern_index_control
   import ws2811_pkg::*;
#(
   parameter int  PATTERNS_NUMBER = DEFAULT_PATTERNS_NUMBER,
   localparam int PW              = index_width(PATTERNS_NUMBER)
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          next_cmd,
   input  logic          prev_cmd,
   output logic [PW-1:0] index
);

   // Step the index; power-of-two pattern count makes natural overflow the wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         index <= '0;
      end else if (next_cmd && !prev_cmd) begin
         index <= index + PW'(1);
      end else if (prev_cmd && !next_cmd) begin
         index <= index - PW'(1);
      end
   end

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Streams one frame of 24-bit colours from the pattern ROM into the WS2811
// transmitter, one word per LED, rotating the pattern by one colour per frame.
//
// Build option: PIXEL_FRAME_PENDING_TICK_EN -- when defined, a frame tick
// arriving mid-frame is remembered (one deep) and starts the next frame as
// soon as the sequencer returns to idle; otherwise such ticks are dropped.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | waiting for a frame tick
// ST_FETCH     | present {active pattern, colour} to the ROM
// ST_WAIT_ROM  | one cycle of ROM read latency
// ST_ISSUE     | capture ROM word, strobe transmitter (when not busy)
// ST_WAIT_ACK  | wait for transmitter busy to rise
// ST_WAIT_DONE | wait for busy to fall, then next unit or finish
// ST_DONE      | one-cycle frame-done pulse
module pixel_frame_sequencer
   import ws2811_pkg::*;
#(
   parameter int  UNITS_NUMBER          = DEFAULT_UNITS_NUMBER,
   parameter int  PATTERN_COLORS_NUMBER = DEFAULT_PATTERN_COLORS_NUMBER,
   parameter int  PATTERNS_NUMBER       = DEFAULT_PATTERNS_NUMBER,
   localparam int CW                    = index_width(PATTERN_COLORS_NUMBER),
   localparam int PW                    = index_width(PATTERNS_NUMBER),
   localparam int UW                    = index_width(UNITS_NUMBER)
)
(
   input  logic             clkIN,
   input  logic             resetIN,
   input  logic             frameTickIN,
   input  logic             patternNextIN,
   input  logic             patternPrevIN,
   output logic [CW+PW-1:0] romAddressOUT,
   input  rgb24_t           romDataIN,
   input  logic             txBusyIN,
   output logic             txStartOUT,
   output rgb24_t           txDataOUT,
   output logic             frameActiveOUT,
   output logic             frameDoneOUT
);

   seq_state_t    state;
   seq_state_t    next_state;
   logic [UW-1:0] unit_index;
   logic [CW-1:0] colour_index;
   logic [CW-1:0] shift;
   logic [PW-1:0] active_pattern;
   logic [PW-1:0] pending_pattern;
   logic          tick_pending;
   logic          start_frame;
   logic          last_unit;

   pattern_index_control #(
      .PATTERNS_NUMBER (PATTERNS_NUMBER)
   ) u_pattern_index (
      .clk      (clkIN),
      .reset    (resetIN),
      .next_cmd (patternNextIN),
      .prev_cmd (patternPrevIN),
      .index    (pending_pattern)
   );

   assign start_frame    = (state == ST_IDLE) && (frameTickIN || tick_pending);
   assign last_unit      = (unit_index == UW'(UNITS_NUMBER - 1));
   assign frameActiveOUT = (state != ST_IDLE);
   assign frameDoneOUT   = (state == ST_DONE);

`ifdef PIXEL_FRAME_PENDING_TICK_EN
   // Remember one overrun tick; it is consumed by the idle cycle that follows.
   always_ff @(posedge clkIN) begin
      if (resetIN) begin
         tick_pending <= 1'b0;
      end else if (state == ST_IDLE) begin
         tick_pending <= 1'b0;
      end else if (frameTickIN) begin
         tick_pending <= 1'b1;
      end
   end
`else
   assign tick_pending = 1'b0;
`endif

   // Next-state decode for the per-unit handshake loop.
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE:      if (start_frame) next_state = ST_FETCH;
         ST_FETCH:     next_state = ST_WAIT_ROM;
         ST_WAIT_ROM:  next_state = ST_ISSUE;
         ST_ISSUE:     if (!txBusyIN) next_state = ST_WAIT_ACK;
         ST_WAIT_ACK:  if (txBusyIN) next_state = ST_WAIT_DONE;
         ST_WAIT_DONE: if (!txBusyIN) next_state = last_unit ? ST_DONE : ST_FETCH;
         ST_DONE:      next_state = ST_IDLE;
         default:      next_state = ST_IDLE;
      endcase
   end

   // State register plus the frame counters and registered ROM/transmit outputs.
   always_ff @(posedge clkIN) begin
      if (resetIN) begin
         state          <= ST_IDLE;
         unit_index     <= '0;
         colour_index   <= '0;
         shift          <= '0;
         active_pattern <= '0;
         romAddressOUT  <= '0;
         txDataOUT      <= '0;
         txStartOUT     <= 1'b0;
      end else begin
         state      <= next_state;
         txStartOUT <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start_frame) begin
                  unit_index     <= '0;
                  colour_index   <= shift;
                  shift          <= shift + CW'(1);
                  active_pattern <= pending_pattern;
               end
            end
            ST_FETCH: begin
               romAddressOUT <= {active_pattern, colour_index};
            end
            ST_ISSUE: begin
               // Holding off while busy keeps the strobe off a busy transmitter.
               if (!txBusyIN) begin
                  txDataOUT  <= romDataIN;
                  txStartOUT <= 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (!txBusyIN && !last_unit) begin
                  unit_index   <= unit_index + UW'(1);
                  colour_index <= colour_index + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Directed bench for pixel_frame_sequencer: 3-unit frames, identity ROM,
// transmitter model holding busy for 10 cycles after an optional ack delay.
module tb_pixel_frame_sequencer;

   localparam int UNITS = 3;
   localparam int COLS  = 128;
   localparam int PATS  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic        pnext = 1'b0;
   logic        pprev = 1'b0;
   logic [8:0]  rom_addr;
   logic [23:0] rom_data = '0;
   logic        busy = 1'b0;
   logic        tx_start;
   logic [23:0] tx_data;
   logic        active;
   logic        done;

   int checks = 0;
   int errors = 0;

   pixel_frame_sequencer #(
      .UNITS_NUMBER          (UNITS),
      .PATTERN_COLORS_NUMBER (COLS),
      .PATTERNS_NUMBER       (PATS)
   ) dut (
      .clkIN          (clk),
      .resetIN        (rst),
      .frameTickIN    (tick),
      .patternNextIN  (pnext),
      .patternPrevIN  (pprev),
      .romAddressOUT  (rom_addr),
      .romDataIN      (rom_data),
      .txBusyIN       (busy),
      .txStartOUT     (tx_start),
      .txDataOUT      (tx_data),
      .frameActiveOUT (active),
      .frameDoneOUT   (done)
   );

   always #5 clk = ~clk;

   // Identity ROM with one cycle of read latency.
   always @(posedge clk) rom_data <= {15'd0, rom_addr};

   // Transmitter model.
   int   ack_delay = 0;
   int   wait_cnt = 0;
   int   busy_cnt = 0;
   logic armed = 1'b0;
   always @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0; armed <= 1'b0; wait_cnt <= 0; busy_cnt <= 0;
      end else if (tx_start) begin
         armed <= 1'b1; wait_cnt <= ack_delay;
      end else if (armed) begin
         if (wait_cnt == 0) begin
            busy <= 1'b1; busy_cnt <= 10; armed <= 1'b0;
         end else begin
            wait_cnt <= wait_cnt - 1;
         end
      end else if (busy) begin
         if (busy_cnt <= 1) busy <= 1'b0;
         busy_cnt <= busy_cnt - 1;
      end
   end

   // Strobe capture and protocol monitors.
   logic [23:0] s_data[$];
   logic [8:0]  s_addr[$];
   int          done_cnt = 0;
   int          busy_viol = 0;
   int          stab_viol = 0;
   logic        have_last = 1'b0;
   logic [23:0] last_data = '0;
   always @(negedge clk) begin
      if (rst) begin
         have_last = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (tx_start) begin
            if (busy) busy_viol++;
            s_data.push_back(tx_data);
            s_addr.push_back(rom_addr);
            last_data = tx_data;
            have_last = 1'b1;
         end else if (have_last && tx_data !== last_data) begin
            stab_viol++;
         end
      end
   end

   task automatic pulse_tick;
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int start = done_cnt;
      int n = 0;
      while (done_cnt == start && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done_cnt == start) begin
         errors++;
         $display("FAIL %s_timeout: frameDoneOUT not seen within %0d cycles", name, n);
      end
   endtask

   task automatic run_frame;
      s_data.delete(); s_addr.delete();
      pulse_tick();
      wait_done("quiet_frame");
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_txstart: got %b want 0", tx_start); end
      checks++; if (tx_data !== 24'd0) begin errors++; $display("FAIL reset_txdata: got %h want 0", tx_data); end
      checks++; if (rom_addr !== 9'd0) begin errors++; $display("FAIL reset_romaddr: got %h want 0", rom_addr); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL idle_after_reset: active got %b want 0", active); end
   endtask

   task automatic test_basic;
      int exp[3] = '{0, 1, 2};
      int d0 = done_cnt;
      s_data.delete(); s_addr.delete();
      pulse_tick();
      @(posedge clk); #1;
      checks++; if (rom_addr !== 9'd0 || active !== 1'b1) begin errors++; $display("FAIL basic_k1: addr %h active %b want 0/1", rom_addr, active); end
      @(posedge clk); #1;
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL basic_k2_start: got %b want 0", tx_start); end
      @(posedge clk); #1;
      checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL basic_k3_start: got %b want 1", tx_start); end
      wait_done("basic");
      repeat (5) @(negedge clk);
      checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL basic_done_count: got %0d want %0d", done_cnt - d0, 1); end
      checks++;
      if (s_data.size() != 3) begin errors++; $display("FAIL basic_strobes: got %0d want 3", s_data.size()); end
      else for (int i = 0; i < 3; i++) begin
         checks++; if (s_data[i] !== 24'(exp[i])) begin errors++; $display("FAIL basic_data%0d: got %0d want %0d", i, s_data[i], exp[i]); end
      end
   endtask

   task automatic test_rotation;
      int exp[3] = '{1, 2, 3};
      run_frame();
      checks++;
      if (s_data.size() != 3) begin errors++; $display("FAIL rot_strobes: got %0d want 3", s_data.size()); end
      else for (int i = 0; i < 3; i++) begin
         checks++; if (s_data[i] !== 24'(exp[i])) begin errors++; $display("FAIL rot_data%0d: got %0d want %0d", i, s_data[i], exp[i]); end
      end
   endtask

   task automatic test_pattern;
      int exp_a[3] = '{2, 3, 4};
      int exp_b[3] = '{131, 132, 133};
      int exp_c[3] = '{388, 389, 390};
      int exp_d[3] = '{389, 390, 391};
      // next mid-frame: this frame stays on pattern 0
      s_data.delete(); s_addr.delete();
      pulse_tick();
      repeat (8) @(posedge clk);
      #1 pnext = 1'b1;
      @(posedge clk); #1 pnext = 1'b0;
      wait_done("pat_mid");
      repeat (3) @(negedge clk);
      checks++;
      if (s_addr.size() != 3) begin errors++; $display("FAIL pat_mid_strobes: got %0d want 3", s_addr.size()); end
      else for (int i = 0; i < 3; i++) begin
         checks++; if (s_addr[i] !== 9'(exp_a[i]) || s_data[i] !== 24'(exp_a[i])) begin errors++; $display("FAIL pat_mid_addr%0d: got %0d want %0d", i, s_addr[i], exp_a[i]); end
      end
      run_frame();
      checks++;
      if (s_addr.size() != 3) begin errors++; $display("FAIL pat_next_strobes: got %0d want 3", s_addr.size()); end
      else for (int i = 0; i < 3; i++) begin
         checks++; if (s_addr[i] !== 9'(exp_b[i]) || s_data[i] !== 24'(exp_b[i])) begin errors++; $display("FAIL pat_next_addr%0d: got %0d want %0d", i, s_addr[i], exp_b[i]); end
      end
      // prev twice: 1 -> 0 -> 3
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1 pprev = 1'b1;
         @(posedge clk); #1 pprev = 1'b0;
      end
      run_frame();
      checks++;
      if (s_addr.size() != 3) begin errors++; $display("FAIL pat_prev_strobes: got %0d want 3", s_addr.size()); end
      else for (int i = 0; i < 3; i++) begin
         checks++; if (s_addr[i] !== 9'(exp_c[i])) begin errors++; $display("FAIL pat_prev_addr%0d: got %0d want %0d", i, s_addr[i], exp_c[i]); end
      end
      // next and prev together: no change
      @(posedge clk); #1 pnext = 1'b1; pprev = 1'b1;
      @(posedge clk); #1 pnext = 1'b0; pprev = 1'b0;
      run_frame();
      checks++;
      if (s_addr.size() != 3) begin errors++; $display("FAIL pat_both_strobes: got %0d want 3", s_addr.size()); end
      else for (int i = 0; i < 3; i++) begin
         checks++; if (s_addr[i] !== 9'(exp_d[i])) begin errors++; $display("FAIL pat_both_addr%0d: got %0d want %0d", i, s_addr[i], exp_d[i]); end
      end
   endtask

   task automatic test_handshake;
      int exp[3] = '{390, 391, 392};
      ack_delay = 4;
      run_frame();
      ack_delay = 0;
      checks++;
      if (s_data.size() != 3) begin errors++; $display("FAIL hs_strobes: got %0d want 3", s_data.size()); end
      else for (int i = 0; i < 3; i++) begin
         checks++; if (s_data[i] !== 24'(exp[i])) begin errors++; $display("FAIL hs_data%0d: got %0d want %0d", i, s_data[i], exp[i]); end
      end
      checks++; if (busy_viol !== 0) begin errors++; $display("FAIL hs_start_while_busy: got %0d want 0", busy_viol); end
      checks++; if (stab_viol !== 0) begin errors++; $display("FAIL hs_data_stable: got %0d changes want 0", stab_viol); end
   endtask

   task automatic test_reset_mid;
      int exp[3] = '{0, 1, 2};
      int n = 0;
      int d0;
      s_data.delete(); s_addr.delete();
      pulse_tick();
      while (s_data.size() < 2 && n < 500) begin @(negedge clk); n++; end
      checks++; if (s_data.size() < 2) begin errors++; $display("FAIL rmid_timeout: strobes got %0d want 2", s_data.size()); end
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      d0 = done_cnt;
      @(posedge clk); #1;
      checks++;
      if (tx_start !== 1'b0 || active !== 1'b0 || done !== 1'b0 || tx_data !== 24'd0 || rom_addr !== 9'd0) begin
         errors++;
         $display("FAIL rmid_outputs: start %b active %b done %b data %h addr %h want all 0", tx_start, active, done, tx_data, rom_addr);
      end
      rst = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (done_cnt !== d0 || active !== 1'b0) begin errors++; $display("FAIL rmid_abandon: done pulses %0d active %b want 0/0", done_cnt - d0, active); end
      run_frame();
      checks++;
      if (s_addr.size() != 3) begin errors++; $display("FAIL rmid_restart_strobes: got %0d want 3", s_addr.size()); end
      else for (int i = 0; i < 3; i++) begin
         checks++; if (s_addr[i] !== 9'(exp[i])) begin errors++; $display("FAIL rmid_restart_addr%0d: got %0d want %0d", i, s_addr[i], exp[i]); end
      end
   endtask

   task automatic test_wrap;
      int exp[3] = '{127, 0, 1};
      for (int f = 0; f < 126; f++) run_frame();
      run_frame();
      checks++;
      if (s_data.size() != 3) begin errors++; $display("FAIL wrap_strobes: got %0d want 3", s_data.size()); end
      else for (int i = 0; i < 3; i++) begin
         checks++; if (s_data[i] !== 24'(exp[i])) begin errors++; $display("FAIL wrap_data%0d: got %0d want %0d", i, s_data[i], exp[i]); end
      end
   endtask

   task automatic test_overrun;
      int n = 0;
      s_data.delete(); s_addr.delete();
      pulse_tick();
      while (s_data.size() < 3 && n < 500) begin @(negedge clk); n++; end
      checks++; if (s_data.size() < 3) begin errors++; $display("FAIL ovr_wait_unit2: strobes got %0d want 3", s_data.size()); end
      pulse_tick();
      n = 0;
      while (done !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL ovr_done_timeout: done got %b want 1", done); end
      @(negedge clk);
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL ovr_idle_after_done: active got %b want 0", active); end
      @(negedge clk);
`ifdef PIXEL_FRAME_PENDING_TICK_EN
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL ovr_pending_start: active got %b want 1", active); end
      wait_done("ovr_pending");
      repeat (3) @(negedge clk);
`else
      repeat (20) @(negedge clk);
      checks++; if (active !== 1'b0 || s_data.size() != 3) begin errors++; $display("FAIL ovr_dropped: active %b strobes %0d want 0/3", active, s_data.size()); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rotation();
      test_pattern();
      test_handshake();
      test_reset_mid();
      test_wrap();
      test_overrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_frame_sequencer.md
# pixel_frame_sequencer

Streams one frame of 24-bit colour words from the pattern ROM into the WS2811 transmitter, one word per LED unit, handshaking on the transmitter's busy flag. It sits between the frame-rate tick and IR pattern commands on the input side, and the pattern ROM and `WS2811Transmitter` on the output side. It rotates the pattern by one colour per frame to produce animation.

## Interface
Parameters:
- `UNITS_NUMBER`, 100: LEDs per frame; must be ≥1.
- `PATTERN_COLORS_NUMBER`, 128: colours per pattern; must be a power of 2.
- `PATTERNS_NUMBER`, 4: patterns in ROM; must be a power of 2.

Ports:
- `clkIN` in 1: system clock. One clock domain.
- `resetIN` in 1: reset, synchronous, active-high.
- `frameTickIN` in 1: one-cycle frame start pulse.
- `patternNextIN` in 1: one-cycle pulse; select the next pattern.
- `patternPrevIN` in 1: one-cycle pulse; select the previous pattern.
- `romAddressOUT` out CW+PW: ROM address, `{pattern, colour}`.
  - PW = clog2(PATTERNS_NUMBER).
  - CW = clog2(PATTERN_COLORS_NUMBER).
- `romDataIN` in 24: ROM word; valid 1 cycle after the address changes.
- `txBusyIN` in 1: transmitter busy.
- `txStartOUT` out 1: one-cycle transmit strobe.
- `txDataOUT` out 24: colour word; held stable from the strobe until the next strobe.
- `frameActiveOUT` out 1: high while a frame is streaming.
- `frameDoneOUT` out 1: one-cycle pulse after the last unit completes.

## Operation
State machine: IDLE → FETCH → WAIT_ROM → ISSUE → WAIT_ACK → WAIT_DONE → (FETCH | DONE) → IDLE.

- **IDLE, on `frameTickIN`:**
  - unitIndex ← 0.
  - colourIndex ← shift.
  - shift ← shift+1 (mod PATTERN_COLORS_NUMBER).
  - Latch the pending pattern into the active pattern.
  - Go to FETCH.
- **FETCH:** `romAddressOUT` ← `{activePattern, colourIndex}`.
- **WAIT_ROM:** one cycle for ROM latency.
- **ISSUE:**
  - `txDataOUT` ← `romDataIN`.
  - `txStartOUT` = 1 for exactly one cycle.
- **WAIT_ACK:** wait for `txBusyIN` = 1.
- **WAIT_DONE:** wait for `txBusyIN` = 0. Then:
  - If unitIndex = UNITS_NUMBER-1, go to DONE.
  - Otherwise: unitIndex+1, colourIndex+1 (wraps mod PATTERN_COLORS_NUMBER), go to FETCH.
- **DONE:** `frameDoneOUT` = 1 for one cycle, then IDLE.

Pattern control:
- Pending pattern increments on next and decrements on prev, wrapping mod PATTERNS_NUMBER.
- Next and prev in the same cycle: no change.
- Pattern commands are accepted in any state, but take effect only at the next frame start, so frames never tear.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Pattern, shift, unitIndex and colourIndex all 0.
- Reset asserted mid-frame: the next cycle is IDLE with `txStartOUT` = 0. The frame is abandoned and `frameDoneOUT` does not pulse.
- Tick sampled at edge k: `romAddressOUT` is valid after edge k+1; `txStartOUT` is high during the cycle after edge k+3.
- Per-unit overhead outside busy time: 5 cycles (FETCH, WAIT_ROM, ISSUE, WAIT_ACK minimum, WAIT_DONE exit).
- `frameActiveOUT` is high in every state except IDLE.
- `txStartOUT` is never asserted while `txBusyIN` is high.
- `frameTickIN` while not in IDLE: behaviour is defined under Configuration.

## Configuration
- Macro `PIXEL_FRAME_PENDING_TICK_EN`.
- **Defined:**
  - A tick arriving outside IDLE sets a one-deep pending flag.
  - On return to IDLE, a set flag starts a new frame on the next cycle and clears the flag.
  - Further ticks while the flag is set are dropped.
- **Undefined:** ticks outside IDLE are dropped.

## Structure
- Package `ws2811_pkg` holds:
  - `rgb24_t` (24-bit colour typedef).
  - `seq_state_t` enum for the states above.
  - Width helper constants derived via `$clog2`.
- Sub-module `pattern_index_control`:
  - Up/down wrap counter for the pending pattern.
  - Inputs: next, prev, clock, reset.
  - Output: index.

## Test plan
- **Basic frame:** `UNITS_NUMBER`=3, ROM[a]=a. Transmitter model holds busy for 10 cycles. One tick → 3 strobes with data 0, 1, 2; `frameDoneOUT` pulses once; shift = 1.
- **Rotation and wrap:** second tick → data 1, 2, 3. Preload shift = 127 → data 127, 0, 1.
- **Pattern control:**
  - Next pulse mid-frame → current frame stays on pattern 0; next frame's addresses use pattern 1.
  - Prev from pattern 0 → pattern 3.
  - Next and prev in the same cycle → no change.
- **Handshake:** busy rises 4 cycles late → no second strobe until busy has risen and fallen; `txDataOUT` stays stable.
- **Reset mid-frame:** reset after unit 1 → all outputs 0 next cycle, no `frameDoneOUT`; a new tick restarts at unit 0 with shift 0.
- **Overrun tick:** tick during unit 2.
  - With macro: a new frame starts 1 cycle after the `frameDoneOUT` cycle.
  - Without macro: the tick is dropped and the block stays in IDLE.
